exu_div_wb_ctl: RTL and testbench
=================================

Name: exu_div_wb_ctl

Overview:
Initiator-side controller for the 32-bit iterative divider. Accepts one divide op from decode, drives the divider's div packet and operands, and tracks the divider through completion. Captures the result and holds it until the integer writeback port grants it. Also supplies a single-entry scoreboard hazard to decode for the in-flight destination register.

Parameters:
DATA_W, 32, operand/result width (only 32 supported; matches divider)
REG_AW, 5, architectural register address width

Ports:
clk  in  1  core clock (single clock domain)
rst_l  in  1  asynchronous active-low reset
flush_lower  in  1  pipeline flush; kills the un-captured divide
dec_div_valid  in  1  decode presents a divide op
dec_div_ready  out  1  block is IDLE and can accept an op
dec_div_unsign  in  1  unsigned op
dec_div_rem  in  1  remainder op (REM/REMU)
dec_div_rd  in  REG_AW  destination register
dec_div_rs1_data  in  DATA_W  dividend
dec_div_rs2_data  in  DATA_W  divisor
div_p  out  div_pkt_t  {valid, unsign, rem} to divider
div_dividend  out  DATA_W  to divider
div_divisor  out  DATA_W  to divider
div_finish  in  1  divider finish (normal or smallnum)
div_out  in  DATA_W  divider result, valid the cycle after div_finish
dec_rs1_en, dec_rs2_en  in  1 each  younger op reads rs1/rs2
dec_rs1_addr, dec_rs2_addr, dec_rd_addr  in  REG_AW each  younger op addresses
dec_rd_en  in  1  younger op writes rd
div_hazard  out  1  younger op must stall
div_busy  out  1  state != IDLE
wb_div_valid  out  1  result ready for writeback
wb_div_rd  out  REG_AW  writeback address
wb_div_data  out  DATA_W  writeback data
wb_div_ready  in  1  writeback port grant
div_busy_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- States are IDLE, BUSY, CAPT, WB_PEND. Reset enters IDLE. All outputs reset to 0, except dec_div_ready, which is 1 in IDLE.
- accept = dec_div_valid & IDLE & ~flush_lower.
- div_p.valid = accept, combinational, one-cycle pulse. div_p.unsign, div_p.rem, div_dividend and div_divisor pass through from dec_* in the accept cycle and are 0 otherwise.
- On accept, register rd, unsign and rem, then go IDLE->BUSY.
- BUSY & div_finish & ~flush_lower -> CAPT. The smallnum finish arrives 1 cycle after accept; a normal finish arrives 33 or 34 cycles after accept.
- CAPT: register div_out into the result register.
  - rd != 0: go CAPT->WB_PEND.
  - rd == 0: go CAPT->IDLE with no writeback.
- WB_PEND: wb_div_valid = 1, with wb_div_rd and wb_div_data held stable. wb_div_ready -> IDLE on the next edge. wb_div_valid never drops without a grant.
- flush_lower in BUSY or CAPT returns to IDLE the next cycle and discards the result.
- flush_lower in WB_PEND is ignored; the result is already committed.
- flush_lower and dec_div_valid in the same cycle: no accept.
- No new accept in the cycle the grant is taken; the first accept is the following cycle.
- div_hazard = (state != IDLE) & (rd_ff != 0) & ((dec_rs1_en & dec_rs1_addr == rd_ff) | (dec_rs2_en & dec_rs2_addr == rd_ff) | (dec_rd_en & dec_rd_addr == rd_ff)). It is combinational from registered state.
- Reset mid-operation: asynchronous return to IDLE. The result is lost and the perf counter is cleared.

Optional Feature:
- Macro: EXU_DIV_PERF_CNT_EN.
- Defined: div_busy_cycles is a 32-bit saturating counter incremented every cycle state != IDLE. It holds at 0xFFFF_FFFF and is cleared only by reset.
- Undefined: div_busy_cycles is tied to 0 and no counter flops exist.

Decomposition:
- Shared package gets the state enum div_wb_state_t (IDLE=2'b00, BUSY=2'b01, CAPT=2'b10, WB_PEND=2'b11), reusing the existing div_pkt_t.
- No sub-module. The divider is instantiated beside this block at the exu level, not inside it.
- Registers use the standard rvdff/rvdffe cells with async clear.

Test Plan:
- Signed DIV 100/7, rd=x5 → CAPT 1 cycle after div_finish; wb_div_valid with rd=5, data=14; held 3 cycles with wb_div_ready=0, then grant → IDLE.
- REMU 0xFFFF_FFFF/16, rd=x3, dec_rs1_en=1 and dec_rs1_addr=3 while BUSY → div_hazard=1 throughout; writeback data=0xF; hazard=0 after grant.
- DIV 9/3 (smallnum) → div_finish 1 cycle after accept; wb_div_data=3 three cycles after accept.
- rd=x0 divide → no wb_div_valid; dec_div_ready returns high 2 cycles after div_finish; div_hazard never asserted.
- flush_lower at cycle 10 of BUSY → IDLE next cycle, no writeback. Flush in WB_PEND → result still written back.
- With EXU_DIV_PERF_CNT_EN, a normal DIV granted immediately → div_busy_cycles advances by the exact BUSY+CAPT+WB_PEND cycle count. Undefined → stays 0.

Source files
------------

// File: rtl/exu_div_wb_ctl_pkg.sv
// exu_div_wb_ctl_pkg
//
// Shared types for the divide writeback controller and the divider beside it.
//   div_pkt_t      : request packet handed to the iterative divider
//   div_wb_state_t : controller state encoding
//   DIV_DATA_W     : operand/result width of the divider
//   DIV_REG_AW     : architectural register address width

package exu_div_wb_ctl_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_REG_AW = 5;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        CAPT    = 2'b10,
        WB_PEND = 2'b11
    } div_wb_state_t;

endpackage

// File: rtl/exu_div_wb_ctl.sv
// exu_div_wb_ctl
//
// Initiator-side controller for the 32-bit iterative divider. It takes one
// divide op from decode, launches it on the divider, waits for the finish,
// captures the result and holds it until the integer writeback port grants
// it. While an op is in flight it flags a register hazard to decode against
// the pending destination register.
//
// Ports:
//   clk, rst_l           : core clock, asynchronous active-low reset
//   flush_lower          : kills a divide whose result is not yet committed
//   dec_div_*            : divide op from decode (valid/ready handshake)
//   div_p, div_dividend,
//   div_divisor          : request to the divider (valid for one cycle)
//   div_finish, div_out  : divider completion; div_out is valid the cycle
//                          after div_finish
//   dec_rs1/rs2/rd_*     : register usage of the younger op in decode
//   div_hazard           : younger op must stall
//   div_busy             : controller is not idle
//   wb_div_*             : writeback request (valid/ready handshake)
//   div_busy_cycles      : busy-cycle perf counter
//
// Build option:
//   EXU_DIV_PERF_CNT_EN  : when defined, div_busy_cycles is a saturating count
//                          of non-idle cycles; otherwise it is tied to zero.

module exu_div_wb_ctl
    import exu_div_wb_ctl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int REG_AW = DIV_REG_AW
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush_lower,

    input  logic              dec_div_valid,
    output logic              dec_div_ready,
    input  logic              dec_div_unsign,
    input  logic              dec_div_rem,
    input  logic [REG_AW-1:0] dec_div_rd,
    input  logic [DATA_W-1:0] dec_div_rs1_data,
    input  logic [DATA_W-1:0] dec_div_rs2_data,

    output div_pkt_t          div_p,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_finish,
    input  logic [DATA_W-1:0] div_out,

    input  logic              dec_rs1_en,
    input  logic              dec_rs2_en,
    input  logic [REG_AW-1:0] dec_rs1_addr,
    input  logic [REG_AW-1:0] dec_rs2_addr,
    input  logic [REG_AW-1:0] dec_rd_addr,
    input  logic              dec_rd_en,
    output logic              div_hazard,
    output logic              div_busy,

    output logic              wb_div_valid,
    output logic [REG_AW-1:0] wb_div_rd,
    output logic [DATA_W-1:0] wb_div_data,
    input  logic              wb_div_ready,

    output logic [31:0]       div_busy_cycles
);

    div_wb_state_t     state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              accept;

    // A flush in the same cycle as a request blocks the accept, so a killed
    // op never reaches the divider.
    assign accept = dec_div_valid & (state_q == IDLE) & ~flush_lower;

    // Next-state and datapath-register selection. The divider latches the
    // operation flavour when div_p.valid pulses, so only the destination
    // register and the result need to be held here. A flush is honoured up
    // to and including the capture cycle; once in WB_PEND the result is
    // committed and only the writeback grant releases it.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    rd_d    = dec_div_rd;
                end
            end
            BUSY: begin
                if (flush_lower) begin
                    state_d = IDLE;
                end else if (div_finish) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (flush_lower) begin
                    state_d = IDLE;
                end else begin
                    result_d = div_out;
                    state_d  = (rd_q != '0) ? WB_PEND : IDLE;
                end
            end
            WB_PEND: begin
                if (wb_div_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    // Divider request: operands are forced to zero outside the accept cycle
    // so the divider inputs stay quiet between ops.
    always_comb begin
        div_p        = '0;
        div_dividend = '0;
        div_divisor  = '0;
        if (accept) begin
            div_p.valid  = 1'b1;
            div_p.unsign = dec_div_unsign;
            div_p.rem    = dec_div_rem;
            div_dividend = dec_div_rs1_data;
            div_divisor  = dec_div_rs2_data;
        end
    end

    // Status, writeback and hazard outputs. Writeback address and data are
    // zero unless the request is up, which keeps them stable while the grant
    // is pending. x0 never creates a hazard because writes to it are dropped.
    always_comb begin
        dec_div_ready = (state_q == IDLE);
        div_busy      = (state_q != IDLE);
        wb_div_valid  = (state_q == WB_PEND);
        wb_div_rd     = '0;
        wb_div_data   = '0;
        if (state_q == WB_PEND) begin
            wb_div_rd   = rd_q;
            wb_div_data = result_q;
        end
        div_hazard = (state_q != IDLE) & (rd_q != '0) &
                     ((dec_rs1_en & (dec_rs1_addr == rd_q)) |
                      (dec_rs2_en & (dec_rs2_addr == rd_q)) |
                      (dec_rd_en  & (dec_rd_addr  == rd_q)));
    end

`ifdef EXU_DIV_PERF_CNT_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;

    // Saturating count of every non-idle cycle; only reset clears it.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if ((state_q != IDLE) && (busy_cnt_q != 32'hFFFF_FFFF)) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign div_busy_cycles = busy_cnt_q;
`else
    assign div_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_exu_div_wb_ctl.sv
// tb_exu_div_wb_ctl
//
// Bench for exu_div_wb_ctl. A behavioural divider model answers div_p with
// a programmable finish latency. Expected writebacks are queued when an op
// is launched and checked when the writeback handshake completes.

`timescale 1ns/1ps

module tb_exu_div_wb_ctl;
    import exu_div_wb_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        flush_lower = 1'b0;
    logic        dec_div_valid = 1'b0;
    logic        dec_div_ready;
    logic        dec_div_unsign = 1'b0;
    logic        dec_div_rem = 1'b0;
    logic [4:0]  dec_div_rd = '0;
    logic [31:0] dec_div_rs1_data = '0;
    logic [31:0] dec_div_rs2_data = '0;
    div_pkt_t    div_p;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_finish;
    logic [31:0] div_out;
    logic        dec_rs1_en = 1'b0;
    logic        dec_rs2_en = 1'b0;
    logic [4:0]  dec_rs1_addr = '0;
    logic [4:0]  dec_rs2_addr = '0;
    logic [4:0]  dec_rd_addr = '0;
    logic        dec_rd_en = 1'b0;
    logic        div_hazard;
    logic        div_busy;
    logic        wb_div_valid;
    logic [4:0]  wb_div_rd;
    logic [31:0] wb_div_data;
    logic        wb_div_ready = 1'b0;
    logic [31:0] div_busy_cycles;

    always #5 clk = ~clk;

    exu_div_wb_ctl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .flush_lower      (flush_lower),
        .dec_div_valid    (dec_div_valid),
        .dec_div_ready    (dec_div_ready),
        .dec_div_unsign   (dec_div_unsign),
        .dec_div_rem      (dec_div_rem),
        .dec_div_rd       (dec_div_rd),
        .dec_div_rs1_data (dec_div_rs1_data),
        .dec_div_rs2_data (dec_div_rs2_data),
        .div_p            (div_p),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_finish       (div_finish),
        .div_out          (div_out),
        .dec_rs1_en       (dec_rs1_en),
        .dec_rs2_en       (dec_rs2_en),
        .dec_rs1_addr     (dec_rs1_addr),
        .dec_rs2_addr     (dec_rs2_addr),
        .dec_rd_addr      (dec_rd_addr),
        .dec_rd_en        (dec_rd_en),
        .div_hazard       (div_hazard),
        .div_busy         (div_busy),
        .wb_div_valid     (wb_div_valid),
        .wb_div_rd        (wb_div_rd),
        .wb_div_data      (wb_div_data),
        .wb_div_ready     (wb_div_ready),
        .div_busy_cycles  (div_busy_cycles)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // RISC-V divide semantics, including divide-by-zero and signed overflow.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic u, input logic r);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (u) return r ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : a;
        return r ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
    endfunction

    // Divider model: finish pulses mlat cycles after the request, and div_out
    // carries the result only in the cycle after finish (its complement
    // otherwise, so a mistimed capture is visible).
    int          mlat = 1;
    int          mcnt;
    logic [31:0] mres;
    assign div_finish = (mcnt == 1);

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mcnt    <= 0;
            mres    <= '0;
            div_out <= '0;
        end else begin
            if (div_p.valid) begin
                mcnt <= mlat;
                mres <= ref_div(div_dividend, div_divisor, div_p.unsign, div_p.rem);
            end else if (flush_lower) begin
                mcnt <= 0;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
            end
            div_out <= div_finish ? mres : ~mres;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Writeback scoreboard.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    always @(negedge clk) begin
        if (rst_l && wb_div_valid && wb_div_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_wb: got rd=%0d data=0x%08h, expected no writeback at %0t",
                         wb_div_rd, wb_div_data, $time);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("wb_rd", {27'd0, wb_div_rd}, {27'd0, mon_e.rd});
                checkOutput("wb_data", wb_div_data, mon_e.data);
            end
        end
    end

    // Vector table.
    typedef struct {
        logic        unsign;
        logic        rem;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[9];

    // Launch one op: wait for ready, drive the request and check the
    // divider-side pass-through in the accept cycle. Returns #1 after the
    // accept edge with the request dropped.
    task automatic doAccept(input logic u, input logic r, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input int lat);
        int w;
        w = 0;
        while (!dec_div_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        dec_div_valid    = 1'b1;
        dec_div_unsign   = u;
        dec_div_rem      = r;
        dec_div_rd       = rd;
        dec_div_rs1_data = a;
        dec_div_rs2_data = b;
        mlat             = lat;
        @(negedge clk);
        checkOutput("accept_ready", {31'd0, dec_div_ready}, 32'd1);
        checkOutput("accept_pvalid", {31'd0, div_p.valid}, 32'd1);
        checkOutput("pass_flags", {30'd0, div_p.unsign, div_p.rem}, {30'd0, u, r});
        checkOutput("pass_dividend", div_dividend, a);
        checkOutput("pass_divisor", div_divisor, b);
        @(posedge clk); #1;
        dec_div_valid    = 1'b0;
        dec_div_rs1_data = '0;
        dec_div_rs2_data = '0;
    endtask

    // Run one table entry end to end, including hold-off of the grant.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          n;
        int          exp_delta;
        logic [31:0] cnt0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        hz_exp;
        dec_rs1_en = (idx % 3 == 0);
        dec_rs2_en = (idx % 3 == 1);
        dec_rd_en  = (idx % 3 == 2);
        dec_rs1_addr = v.rd;
        dec_rs2_addr = v.rd;
        dec_rd_addr  = v.rd;
        hz_exp = (v.rd != 5'd0);
        cnt0 = div_busy_cycles;
        if (v.rd != 5'd0) sb_q.push_back('{v.rd, v.exp_data});
        doAccept(v.unsign, v.rem, v.rd, v.a, v.b, v.lat);
        if (v.hold == 0) wb_div_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checkOutput("pkt_quiet", {29'd0, div_p}, 32'd0);
                checkOutput("busy", {31'd0, div_busy}, 32'd1);
            end
            checkOutput("hazard_busy", {31'd0, div_hazard}, {31'd0, hz_exp});
        end while (!wb_div_valid && n < 200);
        if (!wb_div_valid) begin
            checkOutput("wb_timeout", {31'd0, wb_div_valid}, 32'd1);
        end else begin
            checkOutput("wb_latency", n, v.lat + 2);
            rd0 = wb_div_rd;
            d0  = wb_div_data;
            if (v.hold > 0) begin
                for (int h = 1; h < v.hold; h++) begin
                    @(negedge clk);
                    checkOutput("wb_hold_valid", {31'd0, wb_div_valid}, 32'd1);
                    checkOutput("wb_hold_rd", {27'd0, wb_div_rd}, {27'd0, rd0});
                    checkOutput("wb_hold_data", wb_div_data, d0);
                end
                @(posedge clk); #1;
                wb_div_ready = 1'b1;
                @(negedge clk);
                checkOutput("wb_grant_valid", {31'd0, wb_div_valid}, 32'd1);
            end
        end
        @(posedge clk); #1;
        wb_div_ready = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_grant", {31'd0, dec_div_ready}, 32'd1);
        checkOutput("hazard_idle", {31'd0, div_hazard}, 32'd0);
`ifdef EXU_DIV_PERF_CNT_EN
        exp_delta = v.lat + 2 + v.hold;
`else
        exp_delta = 0;
`endif
        checkOutput("perf_delta", div_busy_cycles - cnt0, exp_delta);
        dec_rs1_en = 1'b0;
        dec_rs2_en = 1'b0;
        dec_rd_en  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'd5,  32'd100,        32'd7,          33, 3, 32'd14};
        vecs[1] = '{1'b1, 1'b1, 5'd3,  32'hFFFF_FFFF,  32'd16,         34, 0, 32'h0000_000F};
        vecs[2] = '{1'b0, 1'b0, 5'd7,  32'd9,          32'd3,          1,  0, 32'd3};
        vecs[3] = '{1'b0, 1'b0, 5'd10, 32'hFFFF_FFEC,  32'd3,          33, 1, 32'hFFFF_FFFA};
        vecs[4] = '{1'b0, 1'b1, 5'd11, 32'hFFFF_FFEC,  32'd3,          1,  2, 32'hFFFF_FFFE};
        vecs[5] = '{1'b0, 1'b0, 5'd12, 32'd5,          32'd0,          1,  0, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 1'b1, 5'd13, 32'd5,          32'd0,          34, 0, 32'd5};
        vecs[7] = '{1'b0, 1'b0, 5'd31, 32'h8000_0000,  32'hFFFF_FFFF,  33, 1, 32'h8000_0000};
        vecs[8] = '{1'b1, 1'b0, 5'd30, 32'd1000,       32'd10,         34, 2, 32'd100};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, dec_div_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, div_busy}, 32'd0);
        checkOutput("rst_wb_valid", {31'd0, wb_div_valid}, 32'd0);
        checkOutput("rst_wb_data", wb_div_data, 32'd0);
        checkOutput("rst_hazard", {31'd0, div_hazard}, 32'd0);
        checkOutput("rst_pkt", {29'd0, div_p}, 32'd0);
        checkOutput("rst_perf", div_busy_cycles, 32'd0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // rd = x0: no writeback, ready two cycles after finish, no hazard.
        dec_rs1_en   = 1'b1;
        dec_rs1_addr = 5'd0;
        wb_div_ready = 1'b1;
        doAccept(1'b0, 1'b0, 5'd0, 32'd50, 32'd5, 33);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            checkOutput("x0_hazard", {31'd0, div_hazard}, 32'd0);
            checkOutput("x0_wb_valid", {31'd0, wb_div_valid}, 32'd0);
            checkOutput("x0_ready", {31'd0, dec_div_ready}, {31'd0, (n >= 35)});
        end
        dec_rs1_en   = 1'b0;
        wb_div_ready = 1'b0;
        @(posedge clk); #1;

        // Flush in BUSY at cycle 10, then flush colliding with a new request.
        doAccept(1'b0, 1'b0, 5'd6, 32'd77, 32'd7, 33);
        repeat (9) @(posedge clk);
        #1;
        flush_lower = 1'b1;
        @(negedge clk);
        checkOutput("flush_busy_still", {31'd0, div_busy}, 32'd1);
        @(posedge clk); #1;
        dec_div_valid    = 1'b1;
        dec_div_rd       = 5'd6;
        dec_div_rs1_data = 32'd1;
        dec_div_rs2_data = 32'd1;
        @(negedge clk);
        checkOutput("flush_idle", {31'd0, div_busy}, 32'd0);
        checkOutput("flush_ready", {31'd0, dec_div_ready}, 32'd1);
        checkOutput("flush_blocks_accept", {31'd0, div_p.valid}, 32'd0);
        @(posedge clk); #1;
        flush_lower      = 1'b0;
        dec_div_valid    = 1'b0;
        dec_div_rs1_data = '0;
        dec_div_rs2_data = '0;
        wb_div_ready     = 1'b1;
        @(negedge clk);
        checkOutput("flush_no_accept", {31'd0, div_busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        wb_div_ready = 1'b0;

        // Flush in CAPT (smallnum op): result discarded.
        doAccept(1'b0, 1'b0, 5'd8, 32'd20, 32'd4, 1);
        @(posedge clk); #1;
        flush_lower = 1'b1;
        @(negedge clk);
        checkOutput("capt_flush_valid", {31'd0, wb_div_valid}, 32'd0);
        @(posedge clk); #1;
        flush_lower  = 1'b0;
        wb_div_ready = 1'b1;
        @(negedge clk);
        checkOutput("capt_flush_idle", {31'd0, div_busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        wb_div_ready = 1'b0;

        // Flush in WB_PEND is ignored.
        sb_q.push_back('{5'd9, 32'd3});
        doAccept(1'b0, 1'b0, 5'd9, 32'd7, 32'd2, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_lower = 1'b1;
        @(negedge clk);
        checkOutput("wbp_flush_valid", {31'd0, wb_div_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wbp_flush_valid2", {31'd0, wb_div_valid}, 32'd1);
        checkOutput("wbp_flush_data", wb_div_data, 32'd3);
        @(posedge clk); #1;
        flush_lower  = 1'b0;
        wb_div_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        wb_div_ready = 1'b0;
        @(negedge clk);
        checkOutput("wbp_done", {31'd0, div_busy}, 32'd0);

        // Asynchronous reset mid-operation.
        @(posedge clk); #1;
        doAccept(1'b0, 1'b0, 5'd4, 32'd99, 32'd9, 33);
        repeat (4) @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        checkOutput("arst_busy", {31'd0, div_busy}, 32'd0);
        checkOutput("arst_ready", {31'd0, dec_div_ready}, 32'd1);
        checkOutput("arst_perf", div_busy_cycles, 32'd0);
        @(posedge clk); #1;
        rst_l        = 1'b1;
        wb_div_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        wb_div_ready = 1'b0;

        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
